osd_ram_write_arbiter: RTL
==========================

OSD_RAM_WRITE_ARBITER -- requirements
Module: osd_ram_write_arbiter

Interface
REQ-001 Parameter PORT_NUM, default 5, number of write ports (2..8).
REQ-002 Parameter AW, default 13, RAM address width.
REQ-003 Parameter DW, default 16, RAM data width.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_wr_valid  input  PORT_NUM  per-port write request.
REQ-007 i_wr_addr  input  PORT_NUM*AW  per-port address; port k at [k*AW +: AW].
REQ-008 i_wr_data  input  PORT_NUM*DW  per-port data; port k at [k*DW +: DW].
REQ-009 o_wr_ready  output  PORT_NUM  per-port grant; one-hot or all-zero.
REQ-010 i_clr_start  input  1  single-cycle pulse requesting full-RAM fill.
REQ-011 i_clr_data  input  DW  fill value, sampled with i_clr_start.
REQ-012 o_clr_busy  output  1  high while fill in progress.
REQ-013 o_ram_we  output  1  registered RAM write enable.
REQ-014 o_ram_addr  output  AW  registered RAM write address.
REQ-015 o_ram_wdata  output  DW  registered RAM write data.

Function
REQ-016 Two states: ARB (normal arbitration) and CLEAR (fill engine).
REQ-017 Transfer on port k occurs in a cycle where i_wr_valid[k] and o_wr_ready[k] are both 1.
REQ-018 In ARB, o_wr_ready is combinational: one-hot at the first port with i_wr_valid set, searching cyclically from rr_ptr upward (wrap PORT_NUM-1 -> 0); all-zero if no valid.
REQ-019 rr_ptr (index register, reset 0) becomes (granted index + 1) mod PORT_NUM after each transfer; unchanged in cycles with no transfer.
REQ-020 Sources hold i_wr_valid, address and data stable until transfer; arbiter does not check this.
REQ-021 Write latency: transfer in cycle N -> o_ram_we=1, o_ram_addr/o_ram_wdata = granted port's values in cycle N+1.
REQ-022 o_ram_we=0 in any cycle following a cycle with no transfer and no fill write; o_ram_addr/o_ram_wdata hold last values.
REQ-023 Sustained throughput: one write per cycle, back-to-back transfers allowed.
REQ-024 i_clr_start in ARB: same cycle o_wr_ready forced all-zero (fill wins over ports); i_clr_data latched; state -> CLEAR next cycle; fill counter cleared to 0.
REQ-025 CLEAR: o_wr_ready all-zero; each cycle o_ram_we=1, o_ram_addr=counter, o_ram_wdata=latched fill value, counter increments.
REQ-026 Fill writes addresses 0..2^AW-1 in order, exactly 2^AW consecutive write cycles, no gaps.
REQ-027 After the write to address 2^AW-1, state -> ARB; arbitration resumes the following cycle; rr_ptr unchanged by fill.
REQ-028 o_clr_busy=1 exactly during CLEAR state cycles.
REQ-029 i_clr_start while in CLEAR ignored; fill not restarted, latched value unchanged.
REQ-030 Pending i_wr_valid during CLEAR waits; no write lost or duplicated.

Reset
REQ-031 i_rst=1 at a clock edge: state=ARB, rr_ptr=0, fill counter=0, latched fill value=0.
REQ-032 Registered outputs after reset: o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_clr_busy=0.
REQ-033 While i_rst=1, o_wr_ready all-zero and i_clr_start ignored.
REQ-034 Reset mid-fill aborts CLEAR immediately; no further fill writes issued.

Verification
REQ-035 Single port: port 2 valid, addr 0x0123, data 0xBEEF -> o_wr_ready=5'b00100 same cycle; next cycle o_ram_we=1, addr 0x0123, data 0xBEEF; rr_ptr=3.
REQ-036 Round-robin: all 5 ports valid continuously from reset -> grants 0,1,2,3,4,0 on consecutive cycles, one RAM write per cycle.
REQ-037 Wrap: rr_ptr=4, only ports 1 and 3 valid -> port 1 granted, then port 3.
REQ-038 Fill: i_clr_start with i_clr_data=0x0000 while port 0 valid -> no grant that cycle; 8192 writes addr 0..8191 data 0x0000, o_clr_busy high 8192 cycles; port 0 granted first cycle after.
REQ-039 Reset at fill address 100 -> o_ram_we=0 next cycle, o_clr_busy=0, state ARB, rr_ptr=0.
REQ-040 Second i_clr_start with 0xFFFF mid-fill -> ignored; all 8192 writes carry original value.

Source files
------------

// File: rtl/osd_ram_write_arbiter.sv
// Round-robin write arbiter for the OSD RAM with a full-RAM fill engine.
// Fill writes are presented on the registered RAM port during every CLEAR cycle.
`timescale 1ns/1ps
module osd_ram_write_arbiter #(
  parameter int PORT_NUM = 5,
  parameter int AW       = 13,
  parameter int DW       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [PORT_NUM-1:0]    i_wr_valid,
  input  logic [PORT_NUM*AW-1:0] i_wr_addr,
  input  logic [PORT_NUM*DW-1:0] i_wr_data,
  output logic [PORT_NUM-1:0]    o_wr_ready,
  input  logic                   i_clr_start,
  input  logic [DW-1:0]          i_clr_data,
  output logic                   o_clr_busy,
  output logic                   o_ram_we,
  output logic [AW-1:0]          o_ram_addr,
  output logic [DW-1:0]          o_ram_wdata
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   clr_val_q, clr_val_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;

  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic            grant_en;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  int              cand;

  // Scan from the highest offset down so the port closest to rr_ptr wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int off = PORT_NUM - 1; off >= 0; off--) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= PORT_NUM) cand = cand - PORT_NUM;
      if (i_wr_valid[PW'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_addr = i_wr_addr[k*AW +: AW];
        sel_data = i_wr_data[k*DW +: DW];
      end
    end
  end

  // A fill request in the same cycle takes priority over every port.
  assign grant_en   = (state_q == ST_ARB) && !i_rst && !i_clr_start && gnt_any;
  assign o_wr_ready = grant_en ? (PORT_NUM'(1) << gnt_idx) : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    clr_val_d   = clr_val_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      ST_ARB: begin
        if (i_clr_start) begin
          state_d     = ST_CLEAR;
          clr_val_d   = i_clr_data;
          cnt_d       = '0;
          ram_we_d    = 1'b1;
          ram_addr_d  = '0;
          ram_wdata_d = i_clr_data;
        end else if (grant_en) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = sel_addr;
          ram_wdata_d = sel_data;
          rr_ptr_d    = (gnt_idx == PW'(PORT_NUM - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '1) begin
          state_d = ST_ARB;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = cnt_q + 1'b1;
          ram_wdata_d = clr_val_q;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      clr_val_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      clr_val_q   <= clr_val_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign o_clr_busy  = (state_q == ST_CLEAR);
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_wdata = ram_wdata_q;

endmodule
